// File: rtl/reduce_gate_pipe.sv
// rtl/reduce_gate_pipe.sv - two-stage valid/ready N-input reduction gate with saturating result counter
module reduce_gate_pipe #(
    parameter int WIDTH = 3,
    parameter int CHUNK = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y,
    output logic             y_err,
    output logic [CNT_W-1:0] res_cnt
);

    localparam int NCH = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW  = NCH * CHUNK;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;

    logic           s1_valid;
    logic [2:0]     s1_op;
    logic [NCH-1:0] s1_and;
    logic [NCH-1:0] s1_or;
    logic [NCH-1:0] s1_xor;

    logic           s2_en;
    logic           s1_en;
    logic           accept;
    logic           consume;

    logic [PW-1:0]  pad_one;
    logic [PW-1:0]  pad_zero;
    logic [NCH-1:0] p_and;
    logic [NCH-1:0] p_or;
    logic [NCH-1:0] p_xor;
    logic           red_y;
    logic           red_err;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en && rst_n;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // Padding bits are chosen as the identity of each partial op so they never change the result.
    genvar i;
    generate
        for (i = 0; i < PW; i++) begin : g_pad
            if (i < WIDTH) begin : g_bit
                assign pad_one[i]  = a[i];
                assign pad_zero[i] = a[i];
            end else begin : g_fill
                assign pad_one[i]  = 1'b1;
                assign pad_zero[i] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        p_and = '0;
        p_or  = '0;
        p_xor = '0;
        for (int k = 0; k < NCH; k++) begin
            p_and[k] = &pad_one[k*CHUNK +: CHUNK];
            p_or[k]  = |pad_zero[k*CHUNK +: CHUNK];
            p_xor[k] = ^pad_zero[k*CHUNK +: CHUNK];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_AND;
            s1_and   <= '0;
            s1_or    <= '0;
            s1_xor   <= '0;
        end else if (s1_en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_op  <= op;
                s1_and <= p_and;
                s1_or  <= p_or;
                s1_xor <= p_xor;
            end
        end
    end

    always_comb begin
        red_y   = 1'b0;
        red_err = 1'b0;
        case (s1_op)
            OP_AND:  red_y = &s1_and;
            OP_OR:   red_y = |s1_or;
            OP_XOR:  red_y = ^s1_xor;
            OP_NAND: red_y = ~&s1_and;
            OP_NOR:  red_y = ~|s1_or;
            OP_XNOR: red_y = ~^s1_xor;
            default: red_err = 1'b1;
        endcase
    end

    // y/y_err only load with a real beat so a bubble never disturbs the last delivered value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= 1'b0;
            y_err     <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y     <= red_y;
                y_err <= red_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_cnt <= '0;
        end else if (consume && (res_cnt != CNT_MAX)) begin
            res_cnt <= res_cnt + 1'b1;
        end
    end

endmodule
